// File: rtl/agc_serial_input_rx.sv
// 8N1 UART receiver and frame parser loading the AGC external input registers.
// Optional macro CHECKSUM_EN adds a trailing ID^HI^LO checksum byte to every frame.
module agc_serial_input_rx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          TIMEOUT_BITS = 20,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx,
   output logic [14:0] dsky_verb,
   output logic [14:0] dsky_noun,
   output logic [14:0] mission_time,
   output logic [14:0] apogee,
   output logic [14:0] perigee,
   output logic [4:0]  update_strobe,
   output logic        frame_err
);

   localparam int CNT_W      = $clog2(CLKS_PER_BIT);
   localparam int HALF       = CLKS_PER_BIT / 2;
   localparam int TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W       = $clog2(TO_CYCLES + 1);
   localparam int NUM_REGS   = 5;

   typedef enum logic [2:0] {
      B_IDLE, B_START, B_DATA, B_STOP, B_WAIT_HIGH
   } byte_state_t;

   typedef enum logic [2:0] {
      F_HUNT, F_ID, F_HI, F_LO, F_CK, F_COMMIT
   } frame_state_t;

   // ------------------------------------------------------------------
   // rx synchronizer; rx_prev gives the synced 1->0 edge
   // ------------------------------------------------------------------
   logic rx_meta, rx_sync, rx_prev;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // ------------------------------------------------------------------
   // Byte FSM
   // ------------------------------------------------------------------
   byte_state_t      byte_state, byte_next;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift_q, shift_n;
   logic             byte_valid;
   logic             stop_err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         byte_state <= B_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift_q    <= '0;
      end else begin
         byte_state <= byte_next;
         bit_cnt    <= bit_cnt_n;
         bit_idx    <= bit_idx_n;
         shift_q    <= shift_n;
      end
   end

   always_comb begin
      byte_next  = byte_state;
      bit_cnt_n  = bit_cnt + CNT_W'(1);
      bit_idx_n  = bit_idx;
      shift_n    = shift_q;
      byte_valid = 1'b0;
      stop_err   = 1'b0;
      case (byte_state)
         B_IDLE: begin
            bit_cnt_n = '0;
            if (rx_prev && !rx_sync) byte_next = B_START;
         end
         B_START: begin
            if (bit_cnt == CNT_W'(HALF - 1)) begin
               bit_cnt_n = '0;
               bit_idx_n = '0;
               // a start bit that is high again at mid-bit was only a glitch
               byte_next = rx_sync ? B_IDLE : B_DATA;
            end
         end
         B_DATA: begin
            if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_n = '0;
               shift_n   = {rx_sync, shift_q[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) byte_next = B_STOP;
            end
         end
         B_STOP: begin
            if (bit_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
               bit_cnt_n = '0;
               if (rx_sync) begin
                  byte_valid = 1'b1;
                  byte_next  = B_IDLE;
               end else begin
                  stop_err  = 1'b1;
                  byte_next = B_WAIT_HIGH;
               end
            end
         end
         B_WAIT_HIGH: begin
            bit_cnt_n = '0;
            if (rx_sync) byte_next = B_IDLE;
         end
         default: begin
            bit_cnt_n = '0;
            byte_next = B_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Inter-byte timeout
   // ------------------------------------------------------------------
   frame_state_t    frame_state, frame_next;
   logic [TO_W-1:0] to_cnt;
   logic            to_active;
   logic            timeout_hit;

   assign to_active = (byte_state == B_IDLE) &&
                      (frame_state inside {F_ID, F_HI, F_LO, F_CK});
   assign timeout_hit = to_active && (to_cnt == TO_W'(TO_CYCLES - 1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)       to_cnt <= '0;
      else if (!to_active) to_cnt <= '0;
      else                to_cnt <= to_cnt + TO_W'(1);
   end

   // ------------------------------------------------------------------
   // Frame FSM and committed registers
   // ------------------------------------------------------------------
   logic [2:0]  id_q, id_n;
   logic [6:0]  hi_q, hi_n;
   logic [14:0] out_q [NUM_REGS];
   logic [14:0] out_n [NUM_REGS];
   logic [4:0]  strobe_q, strobe_n;
   logic        err_q, err_n;
   logic        commit;
   logic [14:0] commit_word;
`ifdef CHECKSUM_EN
   logic [7:0]  lo_q, lo_n;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_state <= F_HUNT;
         id_q        <= '0;
         hi_q        <= '0;
         strobe_q    <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) out_q[i] <= '0;
`ifdef CHECKSUM_EN
         lo_q        <= '0;
`endif
      end else begin
         frame_state <= frame_next;
         id_q        <= id_n;
         hi_q        <= hi_n;
         strobe_q    <= strobe_n;
         err_q       <= err_n;
         for (int i = 0; i < NUM_REGS; i++) out_q[i] <= out_n[i];
`ifdef CHECKSUM_EN
         lo_q        <= lo_n;
`endif
      end
   end

   always_comb begin
      frame_next  = frame_state;
      id_n        = id_q;
      hi_n        = hi_q;
      err_n       = 1'b0;
      commit      = 1'b0;
      commit_word = '0;
`ifdef CHECKSUM_EN
      lo_n        = lo_q;
`endif
      // a dropped byte or an expired gap abandons whatever frame was in flight
      if (stop_err || timeout_hit) begin
         err_n      = 1'b1;
         frame_next = F_HUNT;
      end else begin
         case (frame_state)
            F_HUNT: begin
               if (byte_valid && shift_q == SYNC_BYTE) frame_next = F_ID;
            end
            F_ID: begin
               if (byte_valid) begin
                  if (shift_q <= 8'd4) begin
                     id_n       = shift_q[2:0];
                     frame_next = F_HI;
                  end else begin
                     err_n      = 1'b1;
                     frame_next = F_HUNT;
                  end
               end
            end
            F_HI: begin
               if (byte_valid) begin
                  if (!shift_q[7]) begin
                     hi_n       = shift_q[6:0];
                     frame_next = F_LO;
                  end else begin
                     err_n      = 1'b1;
                     frame_next = F_HUNT;
                  end
               end
            end
            F_LO: begin
               if (byte_valid) begin
`ifdef CHECKSUM_EN
                  lo_n       = shift_q;
                  frame_next = F_CK;
`else
                  commit      = 1'b1;
                  commit_word = {hi_q, shift_q};
                  frame_next  = F_COMMIT;
`endif
               end
            end
            F_CK: begin
`ifdef CHECKSUM_EN
               if (byte_valid) begin
                  if (shift_q == ({5'b0, id_q} ^ {1'b0, hi_q} ^ lo_q)) begin
                     commit      = 1'b1;
                     commit_word = {hi_q, lo_q};
                     frame_next  = F_COMMIT;
                  end else begin
                     err_n      = 1'b1;
                     frame_next = F_HUNT;
                  end
               end
`else
               frame_next = F_HUNT;
`endif
            end
            F_COMMIT: frame_next = F_HUNT;
            default:  frame_next = F_HUNT;
         endcase
      end
   end

   // registers written on the sampling edge so the strobe lands one cycle after the stop sample
   always_comb begin
      strobe_n = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         out_n[i] = out_q[i];
         if (commit && id_q == 3'(i)) begin
            out_n[i]    = commit_word;
            strobe_n[i] = 1'b1;
         end
      end
   end

   assign dsky_verb     = out_q[0];
   assign dsky_noun     = out_q[1];
   assign mission_time  = out_q[2];
   assign apogee        = out_q[3];
   assign perigee       = out_q[4];
   assign update_strobe = strobe_q;
   assign frame_err     = err_q;

endmodule
